// File: rtl/croc_block_remap_pkg.sv
// Shared types and constants for the Croc block remapper.
// Holds the regbus and OBI payload structs, the remap table entry type,
// register offsets and small helpers used by the register file and datapath.
package croc_block_remap_pkg;

  localparam int unsigned RemapNumEntries     = 4;
  localparam int unsigned RemapBlockBytes     = 2048;
  localparam int unsigned RemapMaxOutstanding = 2;
  localparam int unsigned AidWidth            = 4;

  // Register word offsets within the block
  localparam logic [11:0] RegCtrl        = 12'h000;
  localparam logic [11:0] RegStatus      = 12'h004;
  localparam logic [11:0] RegMisscnt     = 12'h008;
  localparam logic [11:0] RegEntryBase   = 12'h010;
  localparam int unsigned RegEntryStride = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef struct packed {
    logic                req;
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [AidWidth-1:0] aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic                gnt;
    logic                rvalid;
    logic [31:0]         rdata;
    logic [AidWidth-1:0] rid;
    logic                err;
  } sbr_obi_rsp_t;

  // Block fields are kept address-aligned: bits below the block size are zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] vblk;
    logic [31:0] pblk;
  } remap_entry_t;

  // Mask selecting the block-number bits of an address
  function automatic logic [31:0] blk_mask(input int unsigned bytes);
    return ~(32'(bytes) - 32'd1);
  endfunction

  // Byte-strobe merge of a register write into its old value
  function automatic logic [31:0] wmerge(input logic [31:0] old, input logic [31:0] wdata,
                                         input logic [3:0] strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

  // Readback value of a VBASE register
  function automatic logic [31:0] vbase_word(input remap_entry_t e);
    return e.vblk | {31'd0, e.valid};
  endfunction

endpackage

// File: rtl/croc_block_remap_regs.sv
// Register file of the block remapper: regbus decode, remap table, CTRL and
// the saturating miss counter.
// Ports: clk/rst; reg_req/reg_rsp regbus (ready in the same cycle as valid);
// miss_inc pulses once per counted miss; outstanding/slice_valid feed STATUS;
// entries/en/miss_err are the registered configuration seen by the datapath.
module croc_block_remap_regs
  import croc_block_remap_pkg::*;
#(
  parameter int unsigned NumEntries = RemapNumEntries,
  parameter int unsigned BlockBytes = RemapBlockBytes
) (
  input  logic                          clk,
  input  logic                          rst,
  input  reg_req_t                      reg_req,
  output reg_rsp_t                      reg_rsp,
  input  logic                          miss_inc,
  input  logic [3:0]                    outstanding,
  input  logic                          slice_valid,
  output remap_entry_t [NumEntries-1:0] entries,
  output logic                          en,
  output logic                          miss_err
);

  localparam logic [31:0] BlkMask = blk_mask(BlockBytes);
  localparam logic [11:0] RegEnd  = 12'(32'(RegEntryBase) + RegEntryStride * NumEntries);

  remap_entry_t [NumEntries-1:0] entries_q;
  logic                          en_q;
  logic                          miss_err_q;
  logic [15:0]                   misscnt_q;

  logic [11:0] off;
  logic [11:0] eoff;
  logic [3:0]  eidx;
  logic        is_pbase;
  logic        in_table;
  logic        wr;
  logic        unused_bits;

  // Entry decode: 8-byte stride, VBASE at +0 and PBASE at +4
  assign off         = reg_req.addr[11:0];
  assign in_table    = (off >= RegEntryBase) && (off < RegEnd);
  assign eoff        = off - RegEntryBase;
  assign eidx        = eoff[6:3];
  assign is_pbase    = eoff[2];
  assign unused_bits = ^{reg_req.addr[31:12], eoff[11:7], eoff[1:0]};
  assign wr          = reg_req.valid && reg_req.write && !reg_rsp.error;

  // Read mux and same-cycle handshake
  always_comb begin
    reg_rsp       = '0;
    reg_rsp.ready = reg_req.valid;
    reg_rsp.error = reg_req.valid && (off >= RegEnd);
    case (off)
      RegCtrl:    reg_rsp.rdata = {30'd0, miss_err_q, en_q};
      RegStatus:  reg_rsp.rdata = {23'd0, slice_valid, 4'd0, outstanding};
      RegMisscnt: reg_rsp.rdata = {16'd0, misscnt_q};
      default: begin
        for (int unsigned i = 0; i < NumEntries; i++) begin
          if (in_table && eidx == 4'(i)) begin
            reg_rsp.rdata = is_pbase ? entries_q[i].pblk : vbase_word(entries_q[i]);
          end
        end
      end
    endcase
  end

  // Configuration state and miss counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q  <= '0;
      en_q       <= 1'b0;
      miss_err_q <= 1'b0;
      misscnt_q  <= '0;
    end else begin
      if (wr && off == RegCtrl && reg_req.wstrb[0]) begin
        en_q       <= reg_req.wdata[0];
        miss_err_q <= reg_req.wdata[1];
      end
      // A write clears the counter even if a miss is counted in the same cycle
      if (wr && off == RegMisscnt) begin
        misscnt_q <= '0;
      end else if (miss_inc && misscnt_q != 16'hFFFF) begin
        misscnt_q <= misscnt_q + 16'd1;
      end
      for (int unsigned i = 0; i < NumEntries; i++) begin
        if (wr && in_table && eidx == 4'(i)) begin
          if (is_pbase) begin
            entries_q[i].pblk <= wmerge(entries_q[i].pblk, reg_req.wdata, reg_req.wstrb) & BlkMask;
          end else begin
            entries_q[i].vblk  <= wmerge(entries_q[i].vblk, reg_req.wdata, reg_req.wstrb) & BlkMask;
            entries_q[i].valid <= reg_req.wstrb[0] ? reg_req.wdata[0] : entries_q[i].valid;
          end
        end
      end
    end
  end

  assign entries  = entries_q;
  assign en       = en_q;
  assign miss_err = miss_err_q;

endmodule

// File: rtl/croc_block_remap.sv
// Programmable block-granular OBI address remapper between the crossbar SRAM
// port and an SRAM bank.
// Ports: clk_i/rst_i (async active-high); reg_req_i/reg_rsp_o configuration
// regbus; sbr_req_i/sbr_rsp_o upstream OBI; mem_req_o/mem_rsp_i downstream OBI.
// Requests are translated on accept, held in a one-entry slice, and tracked
// until answered; table misses can be answered locally with an error.
module croc_block_remap
  import croc_block_remap_pkg::*;
#(
  parameter int unsigned NumEntries     = RemapNumEntries,
  parameter int unsigned BlockBytes     = RemapBlockBytes,
  parameter int unsigned MaxOutstanding = RemapMaxOutstanding
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  reg_req_t     reg_req_i,
  output reg_rsp_t     reg_rsp_o,
  input  sbr_obi_req_t sbr_req_i,
  output sbr_obi_rsp_t sbr_rsp_o,
  output sbr_obi_req_t mem_req_o,
  input  sbr_obi_rsp_t mem_rsp_i
);

  localparam logic [31:0] BlkMask = blk_mask(BlockBytes);

  remap_entry_t [NumEntries-1:0] entries;
  logic                          en;
  logic                          miss_err;
  logic                          miss_inc;

  sbr_obi_req_t        slice_q;
  logic                slice_valid_q;
  logic [3:0]          cnt_q;
  logic                err_pend_q;
  logic [AidWidth-1:0] err_rid_q;

  logic        hit;
  logic [31:0] paddr;
  logic [31:0] xaddr;
  logic        miss;
  logic        local_err;
  logic        mem_present;
  logic        dn_gnt;
  logic        gnt_fwd;
  logic        gnt_err;
  logic        gnt;
  logic        accept;

  croc_block_remap_regs #(
    .NumEntries (NumEntries),
    .BlockBytes (BlockBytes)
  ) i_regs (
    .clk         (clk_i),
    .rst         (rst_i),
    .reg_req     (reg_req_i),
    .reg_rsp     (reg_rsp_o),
    .miss_inc    (miss_inc),
    .outstanding (cnt_q),
    .slice_valid (slice_valid_q),
    .entries     (entries),
    .en          (en),
    .miss_err    (miss_err)
  );

  // Table lookup; iterating downwards lets the lowest hitting index win
  always_comb begin
    hit   = 1'b0;
    paddr = sbr_req_i.addr;
    for (int i = int'(NumEntries) - 1; i >= 0; i--) begin
      if (entries[i].valid && entries[i].vblk == (sbr_req_i.addr & BlkMask)) begin
        hit   = 1'b1;
        paddr = entries[i].pblk | (sbr_req_i.addr & ~BlkMask);
      end
    end
  end

  assign miss      = en && !hit;
  assign local_err = miss && miss_err;
  assign xaddr     = (en && hit) ? paddr : sbr_req_i.addr;

  // Downstream presentation is throttled by the outstanding limit
  assign mem_present = slice_valid_q && (cnt_q < 4'(MaxOutstanding));
  assign dn_gnt      = mem_present && mem_rsp_i.gnt;

  // Local errors wait for an idle datapath so responses stay in order
  assign gnt_fwd  = sbr_req_i.req && (!slice_valid_q || dn_gnt) && !err_pend_q;
  assign gnt_err  = sbr_req_i.req && (cnt_q == 4'd0) && !slice_valid_q && !err_pend_q;
  assign gnt      = !rst_i && (local_err ? gnt_err : gnt_fwd);
  assign accept   = gnt && !local_err;
  assign miss_inc = gnt && miss;

  // Request slice, outstanding counter and pending local error
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slice_q       <= '0;
      slice_valid_q <= 1'b0;
      cnt_q         <= 4'd0;
      err_pend_q    <= 1'b0;
      err_rid_q     <= '0;
    end else begin
      if (accept) begin
        slice_valid_q <= 1'b1;
        slice_q.req   <= 1'b1;
        slice_q.addr  <= xaddr;
        slice_q.we    <= sbr_req_i.we;
        slice_q.be    <= sbr_req_i.be;
        slice_q.wdata <= sbr_req_i.wdata;
        slice_q.aid   <= sbr_req_i.aid;
      end else if (dn_gnt) begin
        slice_valid_q <= 1'b0;
      end
      err_pend_q <= gnt && local_err;
      if (gnt && local_err) err_rid_q <= sbr_req_i.aid;
      case ({dn_gnt, mem_rsp_i.rvalid})
        2'b10:   cnt_q <= cnt_q + 4'd1;
        2'b01:   if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_req_o     = slice_q;
    mem_req_o.req = mem_present;
  end

  // Responses pass through except in the local error cycle
  always_comb begin
    sbr_rsp_o        = '0;
    sbr_rsp_o.gnt    = gnt;
    sbr_rsp_o.rvalid = mem_rsp_i.rvalid;
    sbr_rsp_o.rdata  = mem_rsp_i.rdata;
    sbr_rsp_o.rid    = mem_rsp_i.rid;
    sbr_rsp_o.err    = mem_rsp_i.err;
    if (err_pend_q) begin
      sbr_rsp_o.rvalid = 1'b1;
      sbr_rsp_o.rdata  = 32'd0;
      sbr_rsp_o.rid    = err_rid_q;
      sbr_rsp_o.err    = 1'b1;
    end
  end

endmodule

// File: tb/tb_croc_block_remap.sv
// Scoreboard bench for croc_block_remap with a simple SRAM bank model.
module tb_croc_block_remap;
  import croc_block_remap_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_req_t     reg_req;
  reg_rsp_t     reg_rsp;
  sbr_obi_req_t sbr_req;
  sbr_obi_rsp_t sbr_rsp;
  sbr_obi_req_t mem_req;
  sbr_obi_rsp_t mem_rsp;

  logic        bank_gnt;
  logic        bank_hold;
  logic        bank_rvalid;
  logic [31:0] bank_rdata;
  logic [3:0]  bank_rid;

  always_comb begin
    mem_rsp        = '0;
    mem_rsp.gnt    = bank_gnt;
    mem_rsp.rvalid = bank_rvalid;
    mem_rsp.rdata  = bank_rdata;
    mem_rsp.rid    = bank_rid;
  end

  croc_block_remap dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .reg_req_i (reg_req),
    .reg_rsp_o (reg_rsp),
    .sbr_req_i (sbr_req),
    .sbr_rsp_o (sbr_rsp),
    .mem_req_o (mem_req),
    .mem_rsp_i (mem_rsp)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  rid;
  } up_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } mem_exp_t;

  up_exp_t     up_q[$];
  mem_exp_t    mem_q[$];
  logic [35:0] bank_q[$];
  up_exp_t     up_e;
  mem_exp_t    mem_e;

  function automatic logic [31:0] bank_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Upstream response and downstream request monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (sbr_rsp.rvalid) begin
        if (up_q.size() == 0) begin
          chk("unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          up_e = up_q.pop_front();
          chk("rsp_err", 32'(sbr_rsp.err), 32'(up_e.err));
          chk("rsp_rdata", sbr_rsp.rdata, up_e.rdata);
          chk("rsp_rid", 32'(sbr_rsp.rid), 32'(up_e.rid));
        end
      end
      if (mem_req.req && mem_rsp.gnt) begin
        bank_q.push_back({mem_req.aid, bank_data(mem_req.addr)});
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_req", 32'd1, 32'd0);
        end else begin
          mem_e = mem_q.pop_front();
          chk("mem_addr", mem_req.addr, mem_e.addr);
          chk("mem_we", 32'(mem_req.we), 32'(mem_e.we));
          chk("mem_wdata", mem_req.wdata, mem_e.wdata);
          chk("mem_aid", 32'(mem_req.aid), 32'(mem_e.aid));
        end
      end
    end
  end

  // Bank: answers granted requests in order, one per cycle unless held
  initial begin
    bank_rvalid = 1'b0;
    bank_rdata  = '0;
    bank_rid    = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        bank_q.delete();
        bank_rvalid = 1'b0;
      end else if (!bank_hold && bank_q.size() > 0) begin
        {bank_rid, bank_rdata} = bank_q.pop_front();
        bank_rvalid = 1'b1;
      end else begin
        bank_rvalid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
    reg_req       = '0;
    reg_req.valid = 1'b1;
    reg_req.write = 1'b1;
    reg_req.addr  = addr;
    reg_req.wdata = data;
    reg_req.wstrb = 4'hF;
    @(negedge clk);
    chk("reg_wr_ready", 32'(reg_rsp.ready), 32'd1);
    tick();
    reg_req = '0;
  endtask

  task automatic reg_read(input string name, input logic [31:0] addr, input logic [31:0] exp,
                          input logic exp_err);
    reg_req       = '0;
    reg_req.valid = 1'b1;
    reg_req.addr  = addr;
    @(negedge clk);
    chk(name, reg_rsp.rdata, exp);
    chk({name, "_error"}, 32'(reg_rsp.error), 32'(exp_err));
    tick();
    reg_req = '0;
  endtask

  // Issue one upstream request; expectations are queued at the grant
  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                       input logic [3:0] aid, input logic fwd, input logic [31:0] maddr,
                       input logic err);
    logic    granted;
    up_exp_t ue;
    granted       = 1'b0;
    sbr_req       = '0;
    sbr_req.req   = 1'b1;
    sbr_req.addr  = addr;
    sbr_req.we    = we;
    sbr_req.be    = 4'hF;
    sbr_req.wdata = wdata;
    sbr_req.aid   = aid;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (sbr_rsp.gnt) begin
        granted  = 1'b1;
        ue.err   = err;
        ue.rdata = err ? 32'd0 : bank_data(maddr);
        ue.rid   = aid;
        up_q.push_back(ue);
        if (fwd) mem_q.push_back({maddr, we, wdata, aid});
        break;
      end
    end
    if (!granted) chk("gnt_timeout", 32'd0, 32'd1);
    tick();
    sbr_req.req = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      if (up_q.size() == 0 && mem_q.size() == 0) break;
      tick();
    end
    chk("drain_up_q", 32'(up_q.size()), 32'd0);
    chk("drain_mem_q", 32'(mem_q.size()), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    reg_req   = '0;
    sbr_req   = '0;
    bank_gnt  = 1'b1;
    bank_hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req.req), 32'd0);
    chk("rst_sbr_gnt", 32'(sbr_rsp.gnt), 32'd0);
    chk("rst_sbr_rvalid", 32'(sbr_rsp.rvalid), 32'd0);
    chk("rst_reg_ready", 32'(reg_rsp.ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    reg_read("ctrl_rst", 32'h00, 32'h0, 1'b0);
    reg_read("misscnt_rst", 32'h08, 32'h0, 1'b0);
    reg_read("vbase0_rst", 32'h10, 32'h0, 1'b0);
    reg_read("status_rst", 32'h04, 32'h0, 1'b0);

    // Programming and readback
    reg_write(32'h10, 32'h1000_0801);
    reg_write(32'h14, 32'h1000_0000);
    reg_write(32'h00, 32'h1);
    reg_read("vbase0", 32'h10, 32'h1000_0801, 1'b0);
    reg_read("pbase0", 32'h14, 32'h1000_0000, 1'b0);
    reg_write(32'h1C, 32'h2000_07FF);
    reg_read("pbase1_lowbits", 32'h1C, 32'h2000_0000, 1'b0);
    reg_read("unmapped", 32'h0C, 32'h0, 1'b0);
    reg_read("beyond_table", 32'h30, 32'h0, 1'b1);

    // Hit
    issue(32'h1000_0804, 1'b0, 32'h0, 4'h1, 1'b1, 32'h1000_0004, 1'b0);
    @(negedge clk);
    chk("hit_mem_req_lat", 32'(mem_req.req), 32'd1);
    chk("hit_mem_addr_lat", mem_req.addr, 32'h1000_0004);
    tick();
    drain();

    // Miss with local error
    reg_write(32'h00, 32'h3);
    issue(32'h1000_0400, 1'b1, 32'hAABB_CCDD, 4'h2, 1'b0, 32'h0, 1'b1);
    @(negedge clk);
    chk("miss_rvalid_lat", 32'(sbr_rsp.rvalid), 32'd1);
    chk("miss_err_lat", 32'(sbr_rsp.err), 32'd1);
    chk("miss_no_mem_req", 32'(mem_req.req), 32'd0);
    tick();
    drain();
    reg_read("misscnt_1", 32'h08, 32'd1, 1'b0);

    // Error ordering behind two outstanding hits
    bank_hold = 1'b1;
    issue(32'h1000_0808, 1'b0, 32'h0, 4'h3, 1'b1, 32'h1000_0008, 1'b0);
    issue(32'h1000_080C, 1'b0, 32'h0, 4'h4, 1'b1, 32'h1000_000C, 1'b0);
    tick();
    reg_read("status_two_out", 32'h04, 32'h0000_0002, 1'b0);
    fork
      issue(32'h1000_0000, 1'b0, 32'h0, 4'h7, 1'b0, 32'h0, 1'b1);
      begin
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          chk("err_gnt_withheld", 32'(sbr_rsp.gnt), 32'd0);
        end
        @(posedge clk);
        #1;
        bank_hold = 1'b0;
      end
    join
    drain();
    reg_read("misscnt_2", 32'h08, 32'd2, 1'b0);

    // Priority: entries 0 and 2 both match
    reg_write(32'h20, 32'h1000_0801);
    reg_write(32'h24, 32'h3000_0000);
    reg_write(32'h00, 32'h1);
    issue(32'h1000_0810, 1'b0, 32'h0, 4'h5, 1'b1, 32'h1000_0010, 1'b0);
    reg_write(32'h10, 32'h1000_0800);
    reg_read("vbase0_invalid", 32'h10, 32'h1000_0800, 1'b0);
    issue(32'h1000_0810, 1'b0, 32'h0, 4'h6, 1'b1, 32'h3000_0010, 1'b0);
    drain();

    // Bypass: identity, no miss counting
    reg_write(32'h00, 32'h0);
    issue(32'h1000_0814, 1'b1, 32'h1234_5678, 4'h8, 1'b1, 32'h1000_0814, 1'b0);
    issue(32'h5000_0000, 1'b0, 32'h0, 4'h9, 1'b1, 32'h5000_0000, 1'b0);
    drain();
    reg_read("misscnt_bypass", 32'h08, 32'd2, 1'b0);

    // Miss without error: identity, counted
    reg_write(32'h00, 32'h1);
    issue(32'h5000_0004, 1'b0, 32'h0, 4'hA, 1'b1, 32'h5000_0004, 1'b0);
    drain();
    reg_read("misscnt_3", 32'h08, 32'd3, 1'b0);
    reg_write(32'h08, 32'h0);
    reg_read("misscnt_clr", 32'h08, 32'd0, 1'b0);

    // Backpressure: bank withholds gnt for 5 cycles
    bank_gnt = 1'b0;
    issue(32'h1000_0820, 1'b0, 32'h0, 4'hB, 1'b1, 32'h3000_0020, 1'b0);
    fork
      issue(32'h1000_0824, 1'b0, 32'h0, 4'hC, 1'b1, 32'h3000_0024, 1'b0);
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("bp_mem_req", 32'(mem_req.req), 32'd1);
          chk("bp_mem_addr", mem_req.addr, 32'h3000_0020);
          chk("bp_sbr_gnt", 32'(sbr_rsp.gnt), 32'd0);
        end
        @(posedge clk);
        #1;
        bank_gnt = 1'b1;
      end
    join
    drain();

    // Outstanding limit
    bank_hold = 1'b1;
    issue(32'h1000_0830, 1'b0, 32'h0, 4'hD, 1'b1, 32'h3000_0030, 1'b0);
    issue(32'h1000_0834, 1'b0, 32'h0, 4'hE, 1'b1, 32'h3000_0034, 1'b0);
    issue(32'h1000_0838, 1'b0, 32'h0, 4'hF, 1'b1, 32'h3000_0038, 1'b0);
    reg_read("status_sat", 32'h04, 32'h0000_0102, 1'b0);
    @(negedge clk);
    chk("sat_mem_req", 32'(mem_req.req), 32'd0);
    tick();
    bank_hold = 1'b0;
    drain();

    // Reset mid-transfer
    bank_gnt = 1'b0;
    issue(32'h1000_0840, 1'b0, 32'h0, 4'h1, 1'b1, 32'h3000_0040, 1'b0);
    @(negedge clk);
    chk("pre_rst_mem_req", 32'(mem_req.req), 32'd1);
    tick();
    sbr_req.req  = 1'b1;
    sbr_req.addr = 32'h1000_0844;
    rst          = 1'b1;
    @(negedge clk);
    chk("midrst_mem_req", 32'(mem_req.req), 32'd0);
    chk("midrst_sbr_gnt", 32'(sbr_rsp.gnt), 32'd0);
    chk("midrst_sbr_rvalid", 32'(sbr_rsp.rvalid), 32'd0);
    chk("midrst_reg_ready", 32'(reg_rsp.ready), 32'd0);
    up_q.delete();
    mem_q.delete();
    sbr_req = '0;
    tick();
    rst      = 1'b0;
    bank_gnt = 1'b1;
    reg_read("status_after_rst", 32'h04, 32'h0, 1'b0);
    reg_read("ctrl_after_rst", 32'h00, 32'h0, 1'b0);
    reg_read("vbase2_after_rst", 32'h20, 32'h0, 1'b0);
    repeat (3) tick();
    chk("final_up_q", 32'(up_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
